// File: rtl/crc16_rx_checker_pkg.sv
// Shared constants and state encoding for the CRC-16 receive checker
// and its byte-parallel CRC update.
package crc16_rx_checker_pkg;

  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'h0000;
  localparam int          CRC_BYTES  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } state_t;

endpackage

// File: rtl/crc16_rx_checker_if.sv
// Framed byte stream in, stripped payload plus per-frame status out.
// No ready: a byte is taken on every clk edge with in_valid high; out_valid and frame_done are one-cycle qualifiers.
interface crc16_rx_checker_if #(
  parameter int CNT_W = 9
);
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_last;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             frame_done;
  logic             crc_ok;
  logic             crc_err;
  logic             len_err;
  logic [CNT_W-1:0] frame_len;
  logic             busy;

  modport master (
    output in_valid, in_data, in_last,
    input  out_valid, out_data, frame_done, crc_ok, crc_err, len_err, frame_len, busy
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output out_valid, out_data, frame_done, crc_ok, crc_err, len_err, frame_len, busy
  );
endinterface

// File: rtl/crc16_rx_checker_byte_update.sv
// Combinational CRC-16 (poly 0x8005, non-reflected) advanced by one byte, MSB first.
module crc16_byte_update
  import crc16_rx_checker_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 7; i >= 0; i--) begin
      if (crc_out[15] ^ data[i]) crc_out = {crc_out[14:0], 1'b0} ^ CRC16_POLY;
      else                       crc_out = {crc_out[14:0], 1'b0};
    end
  end

endmodule

// File: rtl/crc16_rx_checker.sv
// Receive-side CRC-16 checker: runs the CRC over payload plus CRC bytes, strips
// the two trailing CRC bytes via a 2-deep delay line and reports pass/fail per frame.
module crc16_rx_checker
  import crc16_rx_checker_pkg::*;
#(
  parameter int MAX_LEN = 256,
  parameter int CNT_W   = 9
) (
  input  logic                clk,
  input  logic                rst,
  crc16_rx_checker_if.slave   bus,
  output state_t              state_dbg
);

  state_t           state;
  logic [15:0]      crc_q;
  logic [15:0]      crc_seed;
  logic [15:0]      crc_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] cnt_inc;
  logic [7:0]       dly0;
  logic [7:0]       dly1;

  // A frame always starts from the init value, so back-to-back frames need no bubble.
  assign crc_seed  = (state == ST_IDLE) ? CRC16_INIT : crc_q;
  assign cnt_inc   = count + CNT_W'(1);
  assign bus.busy  = (state != ST_IDLE);
  assign state_dbg = state;

  crc16_byte_update u_crc (
    .crc_in  (crc_seed),
    .data    (bus.in_data),
    .crc_out (crc_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      crc_q          <= CRC16_INIT;
      count          <= '0;
      dly0           <= '0;
      dly1           <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_data   <= '0;
      bus.frame_done <= 1'b0;
      bus.crc_ok     <= 1'b0;
      bus.crc_err    <= 1'b0;
      bus.len_err    <= 1'b0;
      bus.frame_len  <= '0;
    end else begin
      bus.out_valid  <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.crc_ok     <= 1'b0;
      bus.crc_err    <= 1'b0;
      bus.len_err    <= 1'b0;
      if (bus.in_valid) begin
        case (state)
          ST_IDLE: begin
            crc_q <= crc_next;
            count <= CNT_W'(1);
            dly0  <= bus.in_data;
            dly1  <= '0;
            if (bus.in_last) begin
              bus.frame_done <= 1'b1;
              bus.len_err    <= 1'b1;
              bus.frame_len  <= CNT_W'(1);
              count          <= '0;
              crc_q          <= CRC16_INIT;
            end else begin
              state <= ST_RECV;
            end
          end
          ST_RECV: begin
            crc_q <= crc_next;
            count <= cnt_inc;
            dly0  <= bus.in_data;
            dly1  <= dly0;
            // Once two bytes are buffered, the oldest one is known to be payload.
            if (count >= CNT_W'(CRC_BYTES)) begin
              bus.out_valid <= 1'b1;
              bus.out_data  <= dly1;
            end
            if (bus.in_last) begin
              state          <= ST_IDLE;
              count          <= '0;
              crc_q          <= CRC16_INIT;
              bus.frame_done <= 1'b1;
              bus.frame_len  <= cnt_inc;
              if (cnt_inc <= CNT_W'(CRC_BYTES)) bus.len_err <= 1'b1;
              else if (crc_next == 16'h0000)    bus.crc_ok  <= 1'b1;
              else                              bus.crc_err <= 1'b1;
            end else if (cnt_inc == CNT_W'(MAX_LEN)) begin
              state <= ST_DROP;
            end
          end
          ST_DROP: begin
            if (bus.in_last) begin
              state          <= ST_IDLE;
              count          <= '0;
              crc_q          <= CRC16_INIT;
              bus.frame_done <= 1'b1;
              bus.len_err    <= 1'b1;
              bus.frame_len  <= CNT_W'(MAX_LEN);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/crc16_rx_checker.md
Name: crc16_rx_checker

Overview:
Receive-side companion to the byte-parallel CRC-16 generator. Consumes one framed byte stream per clock, where each frame is payload followed by two CRC bytes (high byte first). It recomputes CRC-16 over the whole frame, strips the two CRC bytes, forwards the payload, and flags pass/fail per frame. It sits directly downstream of the generator/link and feeds the payload sink.

Parameters:
MAX_LEN, 256, maximum frame length in bytes, CRC bytes included; longer frames are rejected.
CNT_W, 9, width of byte counter; must satisfy 2**CNT_W > MAX_LEN.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  in_data/in_last valid this cycle; no backpressure
in_data  input  8  frame byte, MSB first on the wire
in_last  input  1  marks final byte of frame (low CRC byte); qualified by in_valid
out_valid  output  1  payload byte valid
out_data  output  8  payload byte (CRC bytes never appear here)
frame_done  output  1  one-cycle pulse, status below is valid
crc_ok  output  1  frame passed; meaningful with frame_done
crc_err  output  1  residue non-zero; meaningful with frame_done
len_err  output  1  frame <3 bytes or >MAX_LEN; meaningful with frame_done
frame_len  output  CNT_W  total bytes received incl. CRC; meaningful with frame_done
busy  output  1  high while a frame is open (state != IDLE)

Behaviour:
- CRC: poly 0x8005 (x^16+x^15+x^2+1), init 0x0000, non-reflected, no final XOR; 8 bits/cycle, MSB of byte first. Matches generator update.
- Check by residue: CRC run over payload+both CRC bytes; residue 0x0000 -> pass.
- Reset (rst=0, any time incl. mid-frame): state IDLE, crc=0, count=0, 2-byte delay line empty, all outputs 0. Partial frame discarded, no frame_done.
- States: IDLE, RECV, DROP.
  - IDLE: in_valid=1 starts frame: crc updated from 0, count=1, byte into delay line; -> RECV, or if in_last also 1 -> IDLE with frame_done and len_err.
  - RECV: each in_valid byte updates crc, count+1, shifts delay line. in_last -> IDLE. count reaching MAX_LEN without in_last -> DROP.
  - DROP: discard bytes, no out_valid, count saturates at MAX_LEN; in_last -> IDLE with len_err.
- Gaps: in_valid low mid-frame holds all state; no timeout.
- Payload strip: 2-deep delay line; accepting byte n (n>=3) emits byte n-2 next cycle (out_valid registered, latency 1 cycle after the accepting edge). The two bytes remaining at in_last are CRC and are dropped.
- Status: registered; frame_done pulses exactly one cycle after the in_last byte is accepted. Exactly one of crc_ok/crc_err/len_err high during pulse; len_err has priority. All three 0 outside pulse. frame_len = count incl. last byte (MAX_LEN when saturated).
- Back-to-back: new frame may start the cycle right after in_last; next frame's first byte processed from fresh crc=0 (no bubble required). Last payload out_valid and frame_done of frame k may coincide with nothing from frame k+1 (first output of k+1 is at earliest 3 accepts later).
- in_last without in_valid ignored.

Decomposition:
- Shared package: CRC16_POLY=16'h8005, CRC16_INIT=16'h0000, state encoding (IDLE/RECV/DROP), CRC_BYTES=2.
- Sub-module crc16_byte_update: combinational next-CRC from (crc[15:0], data[7:0]); reused later by the generator. Checker holds FSM, counter, delay line, status regs.

Test Plan:
- Frame "123456789" (0x31..0x39) + 0xFE,0xE8, in_last on 0xE8, continuous -> out_data 0x31..0x39 in order, 9 out_valid, frame_done with crc_ok=1, frame_len=11.
- Same frame, last byte 0xE9 -> payload still forwarded, frame_done with crc_err=1, crc_ok=0.
- Frame 0x01,0x80,0x05 with in_valid gaps of 1-3 cycles -> single out_valid 0x01, crc_ok=1, frame_len=3; state held across gaps.
- Two-byte frame 0x00,0x00 (in_last on 2nd) -> no out_valid, frame_done with len_err=1; then MAX_LEN+5 byte frame -> len_err=1, frame_len=MAX_LEN, no out_valid after entering DROP.
- Back-to-back: frame 0x01,0x80,0x05 then immediately 0x00,0x00,0x00 -> two frame_done pulses, both crc_ok=1, outputs 0x01 then 0x00.
- rst asserted after 5 bytes of an 11-byte frame, released, then a valid frame -> no frame_done for aborted frame, outputs 0 during reset, next frame crc_ok=1.
